mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the RISC-V core, directly upstream of writeback: accepts one executed instruction at a time, performs byte-serial loads/stores over the 8-bit RAM port, and presents the register write triple (we/waddr/wdata) that the writeback path commits to the register file. A multi-cycle FSM sequences byte transfers, tolerates a stalled RAM grant, and back-pressures execute while busy.

## Interface
- ADDR_W, 32, width of byte address to RAM
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- rdy  in  1  global ready; low freezes the stage
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage accepts this cycle; high only in IDLE
- ex_wreg  in  1  instruction writes rd
- ex_waddr  in  5  rd index
- ex_wdata  in  32  ALU result (non-load writeback value)
- ex_memop  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW; others treated as none
- ex_maddr  in  ADDR_W  effective address
- ex_sdata  in  32  store data
- ram_req  out  1  byte request valid
- ram_wr  out  1  1 write, 0 read
- ram_addr  out  ADDR_W  byte address
- ram_dout  out  8  write byte
- ram_din  in  8  read byte, valid the cycle after a granted read
- ram_gnt  in  1  request accepted this cycle
- wb_we  out  1  register write enable, one-cycle pulse per instruction
- wb_waddr  out  5  register index
- wb_wdata  out  32  register write data
- misalign  out  1  alignment fault pulse (see Configuration)

## Operation
- States: IDLE, ISSUE, LAST, (transient output register update on completion).
- IDLE: ex_ready=1. On ex_valid: latch fields. memop none -> wb_* loaded next edge, stay IDLE (back-to-back, one per cycle). Memory op -> ISSUE with byte counter k=0, N=1/2/4 for B/H/W.
- ISSUE: ram_req=1, ram_addr=maddr+k (wrap modulo 2^ADDR_W), ram_wr per op, ram_dout=sdata[8k+7:8k] (little-endian). On ram_gnt: k++; granted read sets pending flag; byte N-1 granted -> LAST. ram_gnt low: hold address/data, k unchanged.
- Read capture: when pending flag set, ram_din written to byte lane of the previously granted k; captures overlap with subsequent issues.
- LAST: ram_req=0; for loads wait for final byte capture; then wb_we=ex_wreg, wb_waddr, wb_wdata = assembled value sign-extended (LB/LH) or zero-extended (LBU/LHU/LW); stores give wb_we=0. Return to IDLE.
- wb_waddr=0 passed unchanged; register file discards x0 writes.
- rdy low: no register, counter or state change; ram_req forced 0; RAM holds ram_din stable across rdy-low cycles (system contract).

## Timing
- Reset (async, immediate): state IDLE, ex_ready=1, ram_req=0, ram_wr=0, ram_addr=0, ram_dout=0, wb_we=0, wb_waddr=0, wb_wdata=0, misalign=0; any partial access discarded, no writeback issued.
- Non-memory: accepted edge ending cycle T -> wb_* valid cycle T+1.
- Load, ram_gnt held high, accepted end of T: ram_req cycles T+1..T+N, last byte on ram_din at T+N+1, wb_we high cycle T+N+2, ex_ready high again T+N+2.
- Store: ram_req T+1..T+N, IDLE at T+N+1, wb_we=0.
- Each cycle of ram_gnt=0 or rdy=0 during ISSUE adds one cycle.
- wb_we high for exactly one cycle per accepted instruction with ex_wreg=1.

## Configuration
- MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with maddr[0]=1, or LW/SW with maddr[1:0]!=0, issue no RAM request; misalign pulses one cycle at T+1, wb_we=0, stage stays IDLE.
- Undefined: misaligned accesses proceed byte-serially as normal; misalign tied 0.

## Test plan
- ADD-type, ex_wreg=1, waddr=5, wdata=0x1234_5678 -> next cycle wb_we=1, waddr=5, wdata=0x1234_5678; three consecutive accepted cycle-by-cycle.
- LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, gnt=1 -> ram_addr 0x100..0x103 in T+1..T+4, wb_wdata=0x1234_5678 at T+6.
- LB at 0x3 returning 0x80 -> wb_wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH at 0x20, sdata=0xAABB_CCDD, gnt low on first try for 2 cycles -> ram_wr=1, (0x20,0xDD) held 3 cycles then (0x21,0xCC); wb_we never high.
- rst low mid-LW after 2 bytes -> ram_req=0 immediately, no wb_we; new LW after release completes correctly.
- With MEM_ALIGN_CHECK_EN, LW at 0x102 -> misalign=1 one cycle, no ram_req, wb_we=0; without it, bytes 0x102..0x105 accessed.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RISC-V core, directly upstream of writeback.
// Loads and stores move one byte at a time over an 8-bit RAM port. Non-memory
// instructions pass straight through to the writeback triple. Execute is held off
// (ex_ready low) while a byte-serial access is in flight.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word
// accesses instead of performing them.
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wreg,
  input  logic [4:0]        ex_waddr,
  input  logic [31:0]       ex_wdata,
  input  logic [3:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_maddr,
  input  logic [31:0]       ex_sdata,
  output logic              ram_req,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  input  logic              ram_gnt,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic              misalign
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LAST} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  // Number of bytes moved by an op; zero means "not a memory op".
  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
      OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
      OP_LW, OP_SW:         op_size = 3'd4;
      default:              op_size = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  state_t              state_reg, state_next;
  logic [3:0]          op_reg;
  logic                wreg_reg;
  logic [4:0]          waddr_reg;
  logic [ADDR_W-1:0]   maddr_reg;
  logic [31:0]         sdata_reg;
  logic [2:0]          k_reg;       // index of the byte currently being issued
  logic                pend_reg;    // a read was granted last cycle; ram_din carries it now
  logic [1:0]          lane_reg;    // byte lane that the pending read belongs to
  logic                wb_we_reg;
  logic [4:0]          wb_waddr_reg;
  logic [31:0]         wb_wdata_reg;

  logic [2:0]          ex_size;
  logic                ex_is_mem;
  logic                ex_misal;
  logic                ex_accept;
  logic                start_mem;
  logic [2:0]          size_dec;
  logic                store_op;
  logic                issue;
  logic                grant;
  logic                last_byte;
  logic [31:0]         merged;
  logic [31:0]         load_val;

  assign ex_size   = op_size(ex_memop);
  assign ex_is_mem = (ex_size != 3'd0);
  assign ex_ready  = (state_reg == S_IDLE);
  assign ex_accept = rdy && ex_valid && (state_reg == S_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign ex_misal = ((ex_size == 3'd2) && ex_maddr[0]) ||
                    ((ex_size == 3'd4) && (ex_maddr[1:0] != 2'b00));
`else
  assign ex_misal = 1'b0;
`endif

  assign start_mem = ex_accept && ex_is_mem && !ex_misal;
  assign size_dec  = op_size(op_reg);
  assign store_op  = op_is_store(op_reg);
  assign issue     = (state_reg == S_ISSUE);

  // RAM port: address and write byte are held while the grant is withheld.
  assign ram_req   = issue && rdy;
  assign ram_wr    = issue && store_op;
  assign ram_addr  = issue ? (maddr_reg + ADDR_W'(k_reg)) : '0;
  assign ram_dout  = (issue && store_op) ? sdata_reg[{k_reg[1:0], 3'b000} +: 8] : 8'h00;
  assign grant     = ram_req && ram_gnt;
  assign last_byte = (k_reg == (size_dec - 3'd1));

  // Per-lane read capture. The merged view forwards the byte arriving this cycle so
  // the final byte can be written back on the same edge that captures it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] byte_reg;
      logic       hit;

      assign hit = pend_reg && (lane_reg == 2'(gi));

      // Latch the returned read byte into this lane.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          byte_reg <= 8'h00;
        end else if (rdy && hit) begin
          byte_reg <= ram_din;
        end
      end

      assign merged[8*gi +: 8] = hit ? ram_din : byte_reg;
    end
  endgenerate

  // Sign- or zero-extend the assembled load value.
  always_comb begin
    load_val = merged;
    case (op_reg)
      OP_LB:   load_val = {{24{merged[7]}}, merged[7:0]};
      OP_LH:   load_val = {{16{merged[15]}}, merged[15:0]};
      OP_LBU:  load_val = {24'h000000, merged[7:0]};
      OP_LHU:  load_val = {16'h0000, merged[15:0]};
      default: load_val = merged;
    endcase
  end

  // Next state: stores finish on their last grant, loads take one more cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_mem) state_next = S_ISSUE;
      S_ISSUE: if (grant && last_byte) state_next = store_op ? S_IDLE : S_LAST;
      S_LAST:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, latched instruction fields, byte counter and read-pending tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      op_reg    <= 4'd0;
      wreg_reg  <= 1'b0;
      waddr_reg <= 5'd0;
      maddr_reg <= '0;
      sdata_reg <= 32'd0;
      k_reg     <= 3'd0;
      pend_reg  <= 1'b0;
      lane_reg  <= 2'd0;
    end else if (rdy) begin
      state_reg <= state_next;
      if (ex_accept) begin
        op_reg    <= ex_memop;
        wreg_reg  <= ex_wreg;
        waddr_reg <= ex_waddr;
        maddr_reg <= ex_maddr;
        sdata_reg <= ex_sdata;
      end
      if (start_mem) begin
        k_reg <= 3'd0;
      end else if (grant) begin
        k_reg <= k_reg + 3'd1;
      end
      pend_reg <= grant && !store_op;
      lane_reg <= k_reg[1:0];
    end
  end

  // Writeback triple: one-cycle pulse for pass-through ops and completed loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we_reg    <= 1'b0;
      wb_waddr_reg <= 5'd0;
      wb_wdata_reg <= 32'd0;
    end else if (rdy) begin
      wb_we_reg <= 1'b0;
      if (ex_accept && !ex_is_mem) begin
        wb_we_reg    <= ex_wreg;
        wb_waddr_reg <= ex_waddr;
        wb_wdata_reg <= ex_wdata;
      end else if (state_reg == S_LAST) begin
        wb_we_reg    <= wreg_reg;
        wb_waddr_reg <= waddr_reg;
        wb_wdata_reg <= load_val;
      end
    end
  end

  assign wb_we    = wb_we_reg;
  assign wb_waddr = wb_waddr_reg;
  assign wb_wdata = wb_wdata_reg;

`ifdef MEM_ALIGN_CHECK_EN
  logic misal_reg;

  // One-cycle fault pulse for a trapped misaligned access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misal_reg <= 1'b0;
    end else if (rdy) begin
      misal_reg <= ex_accept && ex_is_mem && ex_misal;
    end
  end

  assign misalign = misal_reg;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed timing checks plus randomized instruction stream for mem_stage.
// A byte-level reference memory and queues of expected RAM accesses / writebacks are
// built from the instruction semantics; monitors compare the DUT against them.
module tb_mem_stage;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_wreg;
  logic [4:0]        ex_waddr;
  logic [31:0]       ex_wdata;
  logic [3:0]        ex_memop;
  logic [ADDR_W-1:0] ex_maddr;
  logic [31:0]       ex_sdata;
  logic              ram_req;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;
  logic              ram_gnt;
  logic              wb_we;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_wdata;
  logic              misalign;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wreg(ex_wreg),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_memop(ex_memop),
    .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
    .ram_req(ram_req), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_din(ram_din), .ram_gnt(ram_gnt),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic wr; logic [31:0] addr; logic [7:0] data;} acc_t;
  typedef struct packed {logic [4:0] waddr; logic [31:0] wdata;} wb_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn = 0;
  int          exp_mis = 0;
  bit          gnt_rand = 0;
  logic [7:0]  ram_din_next = 8'h00;
  acc_t        exp_acc[$];
  wb_t         exp_wb[$];
  logic [7:0]  ram_mem [logic [31:0]];   // what the RAM actually holds
  logic [7:0]  ref_mem [logic [31:0]];   // what the instruction stream says it should hold

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  // Reference model: expected RAM traffic and writeback for one accepted instruction.
  task automatic model_push(input logic [3:0] op, input logic wreg, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] sd);
    int n;
    bit st;
    logic [31:0] val;
    logic [31:0] a;
    logic [7:0] b;
    n = 0; st = 0; val = 32'd0;
    case (op)
      4'd1, 4'd4: n = 1;
      4'd2, 4'd5: n = 2;
      4'd3:       n = 4;
      4'd8:  begin n = 1; st = 1; end
      4'd9:  begin n = 2; st = 1; end
      4'd10: begin n = 4; st = 1; end
      default: n = 0;
    endcase
    if (n == 0) begin
      if (wreg) exp_wb.push_back(wb_t'{waddr: wa, wdata: wd});
      return;
    end
`ifdef MEM_ALIGN_CHECK_EN
    if ((ma % 32'(n)) != 0) begin
      exp_mis++;
      return;
    end
`endif
    for (int i = 0; i < n; i++) begin
      a = ma + 32'(i);
      if (st) begin
        b = sd[8*i +: 8];
        exp_acc.push_back(acc_t'{wr: 1'b1, addr: a, data: b});
        ref_mem[a] = b;
      end else begin
        b = ref_rd(a);
        val = val + (32'(b) << (8*i));
        exp_acc.push_back(acc_t'{wr: 1'b0, addr: a, data: b});
      end
    end
    if (!st) begin
      if (op == 4'd1 && val >= 32'h80)   val = val + 32'hFFFF_FF00;
      if (op == 4'd2 && val >= 32'h8000) val = val + 32'hFFFF_0000;
      if (wreg) exp_wb.push_back(wb_t'{waddr: wa, wdata: val});
    end
  endtask

  // RAM model and output monitors, sampled mid-cycle.
  always @(negedge clk) begin : mon
    acc_t e;
    wb_t  w;
    if (rst) begin
      if (ram_req && ram_gnt) begin
        check_eq("acc_expected", 32'(exp_acc.size() == 0), 32'd0);
        if (exp_acc.size() != 0) begin
          e = exp_acc.pop_front();
          check_eq("ram_addr", ram_addr, e.addr);
          check_eq("ram_wr", 32'(ram_wr), 32'(e.wr));
          if (e.wr) check_eq("ram_dout", 32'(ram_dout), 32'(e.data));
        end
        if (ram_wr) ram_mem[ram_addr] = ram_dout;
        else        ram_din_next = ram_rd(ram_addr);
      end
      if (wb_we) begin
        check_eq("wb_expected", 32'(exp_wb.size() == 0), 32'd0);
        if (exp_wb.size() != 0) begin
          w = exp_wb.pop_front();
          check_eq("wb_waddr", 32'(wb_waddr), 32'(w.waddr));
          check_eq("wb_wdata", wb_wdata, w.wdata);
        end
      end
      if (misalign) begin
        check_eq("mis_expected", 32'(exp_mis == 0), 32'd0);
        if (exp_mis > 0) exp_mis--;
      end
    end
  end

  // Read data appears the cycle after the grant and stays until the next read.
  always @(posedge clk) ram_din <= ram_din_next;

  // Random grant generator, active only in randomized sections.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gnt_rand) ram_gnt = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic wreg, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] sd);
    ex_valid = 1'b1;
    ex_memop = op;
    ex_wreg  = wreg;
    ex_waddr = wa;
    ex_wdata = wd;
    ex_maddr = ma;
    ex_sdata = sd;
    model_push(op, wreg, wa, wd, ma, sd);
    n_txn++;
    $display("txn %0d: op=%0d wreg=%0b rd=%0d wdata=%h addr=%h sdata=%h",
             n_txn, op, wreg, wa, wd, ma, sd);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (!ex_ready && c < budget) begin
      step();
      c++;
    end
    check_eq("ex_ready_return", 32'(ex_ready), 32'd1);
  endtask

  task automatic send(input logic [3:0] op, input logic wreg, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] sd);
    present(op, wreg, wa, wd, ma, sd);
    step();
    ex_valid = 1'b0;
    wait_idle(200);
  endtask

  logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10,
                           4'd6, 4'd7, 4'd11, 4'd15};

  initial begin
    logic [31:0] ma;
    rst = 1'b0; rdy = 1'b1; ex_valid = 1'b0; ram_gnt = 1'b0;
    ex_wreg = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_memop = 4'd0;
    ex_maddr = '0; ex_sdata = 32'd0;
    step(); step();

    // Reset state
    check_eq("rst_ex_ready", 32'(ex_ready), 32'd1);
    check_eq("rst_ram_req", 32'(ram_req), 32'd0);
    check_eq("rst_ram_wr", 32'(ram_wr), 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    check_eq("rst_ram_dout", 32'(ram_dout), 32'd0);
    check_eq("rst_wb_we", 32'(wb_we), 32'd0);
    check_eq("rst_wb_waddr", 32'(wb_waddr), 32'd0);
    check_eq("rst_wb_wdata", wb_wdata, 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b1;
    step();

    // Three back-to-back pass-through instructions
    for (int i = 0; i < 3; i++) begin
      present(4'd0, 1'b1, 5'd5, 32'h1234_5678 + 32'(i) * 32'h1111_1111, 32'd0, 32'd0);
      step();
      check_eq("alu_wb_we", 32'(wb_we), 32'd1);
      check_eq("alu_wb_waddr", 32'(wb_waddr), 32'd5);
      check_eq("alu_wb_wdata", wb_wdata, 32'h1234_5678 + 32'(i) * 32'h1111_1111);
      check_eq("alu_ex_ready", 32'(ex_ready), 32'd1);
    end
    ex_valid = 1'b0;
    step();
    check_eq("alu_wb_we_drop", 32'(wb_we), 32'd0);

    // LW at 0x100 with grant held high: exact cycle timing
    ram_mem[32'h100] = 8'h78; ram_mem[32'h101] = 8'h56;
    ram_mem[32'h102] = 8'h34; ram_mem[32'h103] = 8'h12;
    ref_mem[32'h100] = 8'h78; ref_mem[32'h101] = 8'h56;
    ref_mem[32'h102] = 8'h34; ref_mem[32'h103] = 8'h12;
    ram_gnt = 1'b1;
    present(4'd3, 1'b1, 5'd9, 32'd0, 32'h100, 32'd0);
    step();
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("lw_req", 32'(ram_req), 32'd1);
      check_eq("lw_addr", ram_addr, 32'h100 + 32'(i));
      check_eq("lw_ex_ready", 32'(ex_ready), 32'd0);
      step();
    end
    check_eq("lw_req_last", 32'(ram_req), 32'd0);
    check_eq("lw_we_early", 32'(wb_we), 32'd0);
    check_eq("lw_ready_last", 32'(ex_ready), 32'd0);
    step();
    check_eq("lw_wb_we", 32'(wb_we), 32'd1);
    check_eq("lw_wb_wdata", wb_wdata, 32'h1234_5678);
    check_eq("lw_ready_back", 32'(ex_ready), 32'd1);
    step();

    // LB / LBU of 0x80
    ram_mem[32'h3] = 8'h80; ref_mem[32'h3] = 8'h80;
    send(4'd1, 1'b1, 5'd3, 32'd0, 32'h3, 32'd0);
    step();
    check_eq("lb_sext", wb_wdata, 32'hFFFF_FF80);
    send(4'd4, 1'b1, 5'd3, 32'd0, 32'h3, 32'd0);
    step();
    check_eq("lbu_zext", wb_wdata, 32'h0000_0080);

    // SH at 0x20 with grant withheld for two cycles
    ram_gnt = 1'b0;
    present(4'd9, 1'b1, 5'd4, 32'd0, 32'h20, 32'hAABB_CCDD);
    step();
    ex_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) ram_gnt = 1'b1;
      check_eq("sh_req", 32'(ram_req), 32'd1);
      check_eq("sh_wr", 32'(ram_wr), 32'd1);
      check_eq("sh_addr0", ram_addr, 32'h20);
      check_eq("sh_dout0", 32'(ram_dout), 32'hDD);
      check_eq("sh_no_we", 32'(wb_we), 32'd0);
      step();
    end
    check_eq("sh_addr1", ram_addr, 32'h21);
    check_eq("sh_dout1", 32'(ram_dout), 32'hCC);
    check_eq("sh_no_we", 32'(wb_we), 32'd0);
    step();
    check_eq("sh_idle", 32'(ex_ready), 32'd1);
    check_eq("sh_req_end", 32'(ram_req), 32'd0);
    check_eq("sh_no_we", 32'(wb_we), 32'd0);

    // rdy low during ISSUE freezes the access
    present(4'd3, 1'b1, 5'd11, 32'd0, 32'h40, 32'd0);
    step();
    ex_valid = 1'b0;
    check_eq("rdy_addr0", ram_addr, 32'h40);
    step();
    rdy = 1'b0;
    #1;
    check_eq("rdy_req_low", 32'(ram_req), 32'd0);
    check_eq("rdy_addr_hold", ram_addr, 32'h41);
    step();
    check_eq("rdy_addr_frozen", ram_addr, 32'h41);
    check_eq("rdy_not_ready", 32'(ex_ready), 32'd0);
    rdy = 1'b1;
    wait_idle(50);
    step();

    // Reset in the middle of a LW after two bytes
    present(4'd3, 1'b1, 5'd12, 32'd0, 32'h80, 32'd0);
    step();
    ex_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(ram_req), 32'd0);
    check_eq("mid_rst_ready", 32'(ex_ready), 32'd1);
    check_eq("mid_rst_we", 32'(wb_we), 32'd0);
    exp_acc.delete();
    exp_wb.delete();
    step();
    rst = 1'b1;
    step(); step(); step();
    gnt_rand = 1'b1;
    send(4'd3, 1'b1, 5'd13, 32'd0, 32'h84, 32'd0);
    step();
    gnt_rand = 1'b0;
    ram_gnt = 1'b1;

    // LW at 0x102: trapped or performed byte-serially depending on the build
    present(4'd3, 1'b1, 5'd7, 32'd0, 32'h102, 32'd0);
    step();
    ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("mis_pulse", 32'(misalign), 32'd1);
    check_eq("mis_no_req", 32'(ram_req), 32'd0);
    check_eq("mis_idle", 32'(ex_ready), 32'd1);
    step();
    check_eq("mis_pulse_end", 32'(misalign), 32'd0);
    check_eq("mis_no_we", 32'(wb_we), 32'd0);
`else
    check_eq("unal_no_mis", 32'(misalign), 32'd0);
    check_eq("unal_req", 32'(ram_req), 32'd1);
    check_eq("unal_addr", ram_addr, 32'h102);
    wait_idle(50);
    step();
    check_eq("unal_waddr", 32'(wb_waddr), 32'd7);
`endif

    // Randomized instruction stream
    gnt_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0) ma = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           ma = 32'($urandom_range(0, 63));
      send(ops[$urandom_range(0, 12)], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, ma, $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    gnt_rand = 1'b0;
    step(); step(); step();

    check_eq("acc_left", 32'(exp_acc.size()), 32'd0);
    check_eq("wb_left", 32'(exp_wb.size()), 32'd0);
    check_eq("mis_left", 32'(exp_mis), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
